bbox_tracker: RTL and testbench

BBOX_TRACKER -- requirements
Module: bbox_tracker

---
 rtl/bbox_tracker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bbox_tracker.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_tracker.sv
// ---------------------------------------------------------------------------
// bbox_tracker
//
// Tracks a bright (near-white) object in a VGA camera stream, one pixel per
// clock. Each frame it accumulates the bounding box and count of matching
// pixels inside a search window. At frame end it either commits a new box or
// counts a miss. Two states:
//   SEARCH : window is the full active frame
//   TRACK  : window is the committed box widened by MARGIN on every side,
//            clamped to the active frame
//
// Optional feature macro: TRACKER_SMOOTH_EN
//   defined   -> a commit while already tracking writes (old+new)>>1 per
//                coordinate; a commit from SEARCH loads raw values
//   undefined -> every commit loads the raw min/max values
//
// Ports
//   CLK, RESET                 pixel clock, synchronous active-high reset
//   DrawX, DrawY               current pixel coordinate
//   VGA_R, VGA_G, VGA_B        camera colour of the current pixel
//   Tracktlx/tly/brx/bry       committed box (top-left, bottom-right)
//   box_valid                  one-cycle pulse on each box commit
//   locked                     high while in TRACK (exposes the FSM state)
//   lost                       one-cycle pulse on TRACK -> SEARCH
//   match                      combinational: pixel in window and bright
//   pix_count                  matched-pixel count of the last frame
//
// Handshake: there is no back-pressure. Every cycle presents one pixel; the
// box outputs are valid while box_valid pulses and hold until the next commit.
// ---------------------------------------------------------------------------
module bbox_tracker #(
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MARGIN      = 5,
    parameter int THRESH      = 254,
    parameter int MIN_PIXELS  = 4,
    parameter int LOST_FRAMES = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COLOR_W-1:0] VGA_R,
    input  logic [COLOR_W-1:0] VGA_G,
    input  logic [COLOR_W-1:0] VGA_B,
    output logic [COORD_W-1:0] Tracktlx,
    output logic [COORD_W-1:0] Tracktly,
    output logic [COORD_W-1:0] Trackbrx,
    output logic [COORD_W-1:0] Trackbry,
    output logic               box_valid,
    output logic               locked,
    output logic               lost,
    output logic               match,
    output logic [18:0]        pix_count
);

    // Two extra bits so box+MARGIN never wraps before clamping.
    localparam int EXT_W  = COORD_W + 2;
    localparam int CNT_W  = 19;
    localparam int MISS_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    localparam logic [EXT_W-1:0]   L_XMAX      = EXT_W'(H_ACTIVE - 1);
    localparam logic [EXT_W-1:0]   L_YMAX      = EXT_W'(V_ACTIVE - 1);
    localparam logic [EXT_W-1:0]   L_HACT      = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0]   L_VACT      = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0]   L_MARGIN    = EXT_W'(MARGIN);
    localparam logic [COLOR_W-1:0] L_THRESH    = COLOR_W'(THRESH);
    localparam logic [CNT_W-1:0]   L_MIN       = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0]   L_CNT_MAX   = '1;
    localparam logic [MISS_W-1:0]  L_MISS_LAST = MISS_W'(LOST_FRAMES - 1);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_TRACK  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MISS_W-1:0]   r_miss;
    logic [MISS_W-1:0]   w_miss_nxt;
    logic                w_commit;
    logic                w_lost;

    logic [COORD_W-1:0]  r_minx, r_maxx, r_miny, r_maxy;
    logic [CNT_W-1:0]    r_cnt;
    logic [COORD_W-1:0]  w_acc_minx, w_acc_maxx, w_acc_miny, w_acc_maxy;
    logic [CNT_W-1:0]    w_acc_cnt;

    logic [COORD_W-1:0]  r_tlx, r_tly, r_brx, r_bry;
    logic [COORD_W-1:0]  w_new_tlx, w_new_tly, w_new_brx, w_new_bry;
    logic                r_box_valid;
    logic                r_lost;
    logic [CNT_W-1:0]    r_pix_count;

    logic [EXT_W-1:0]    w_x_ext, w_y_ext;
    logic [EXT_W-1:0]    w_win_x_lo, w_win_x_hi, w_win_y_lo, w_win_y_hi;
    logic                w_in_frame, w_in_win, w_bright;
    logic                w_frame_start, w_frame_end;

    assign w_x_ext = {2'b00, DrawX};
    assign w_y_ext = {2'b00, DrawY};

    // Search window. The state/box registers only change at frame end, so
    // using them directly means a new box takes effect from the next frame.
    always_comb begin
        w_win_x_lo = '0;
        w_win_x_hi = L_XMAX;
        w_win_y_lo = '0;
        w_win_y_hi = L_YMAX;
        if (r_state == S_TRACK) begin
            w_win_x_lo = ({2'b00, r_tlx} < L_MARGIN) ? '0 : ({2'b00, r_tlx} - L_MARGIN);
            w_win_y_lo = ({2'b00, r_tly} < L_MARGIN) ? '0 : ({2'b00, r_tly} - L_MARGIN);
            w_win_x_hi = (({2'b00, r_brx} + L_MARGIN) > L_XMAX) ? L_XMAX
                                                                : ({2'b00, r_brx} + L_MARGIN);
            w_win_y_hi = (({2'b00, r_bry} + L_MARGIN) > L_YMAX) ? L_YMAX
                                                                : ({2'b00, r_bry} + L_MARGIN);
        end
    end

    assign w_in_frame = (w_x_ext < L_HACT) && (w_y_ext < L_VACT);
    assign w_in_win   = (w_x_ext >= w_win_x_lo) && (w_x_ext <= w_win_x_hi) &&
                        (w_y_ext >= w_win_y_lo) && (w_y_ext <= w_win_y_hi);
    assign w_bright   = (VGA_R >= L_THRESH) && (VGA_G >= L_THRESH) && (VGA_B >= L_THRESH);
    assign match      = w_in_frame && w_in_win && w_bright;

    assign w_frame_start = (DrawX == '0) && (DrawY == '0);
    assign w_frame_end   = (w_x_ext == L_XMAX) && (w_y_ext == L_YMAX);

    // Accumulator next value including the current pixel. At frame start the
    // previous frame is dropped; at frame end this merged value is what gets
    // evaluated, so the last pixel is included without an extra cycle.
    always_comb begin
        w_acc_minx = r_minx;
        w_acc_maxx = r_maxx;
        w_acc_miny = r_miny;
        w_acc_maxy = r_maxy;
        w_acc_cnt  = r_cnt;
        if (w_frame_start) begin
            if (match) begin
                w_acc_minx = DrawX;
                w_acc_maxx = DrawX;
                w_acc_miny = DrawY;
                w_acc_maxy = DrawY;
                w_acc_cnt  = CNT_W'(1);
            end else begin
                w_acc_minx = '1;
                w_acc_maxx = '0;
                w_acc_miny = '1;
                w_acc_maxy = '0;
                w_acc_cnt  = '0;
            end
        end else if (match) begin
            if (DrawX < r_minx) w_acc_minx = DrawX;
            if (DrawX > r_maxx) w_acc_maxx = DrawX;
            if (DrawY < r_miny) w_acc_miny = DrawY;
            if (DrawY > r_maxy) w_acc_maxy = DrawY;
            if (r_cnt != L_CNT_MAX) w_acc_cnt = r_cnt + CNT_W'(1);
        end
    end

    // FSM next-state and frame-end decision.
    always_comb begin
        w_state_nxt = r_state;
        w_miss_nxt  = r_miss;
        w_commit    = 1'b0;
        w_lost      = 1'b0;
        if (w_frame_end) begin
            if (w_acc_cnt >= L_MIN) begin
                w_commit    = 1'b1;
                w_state_nxt = S_TRACK;
                w_miss_nxt  = '0;
            end else if (r_state == S_TRACK) begin
                if (r_miss == L_MISS_LAST) begin
                    w_state_nxt = S_SEARCH;
                    w_lost      = 1'b1;
                    w_miss_nxt  = '0;
                end else begin
                    w_miss_nxt  = r_miss + MISS_W'(1);
                end
            end
        end
    end

`ifdef TRACKER_SMOOTH_EN
    function automatic logic [COORD_W-1:0] f_avg(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COORD_W:1];
    endfunction

    always_comb begin
        w_new_tlx = w_acc_minx;
        w_new_tly = w_acc_miny;
        w_new_brx = w_acc_maxx;
        w_new_bry = w_acc_maxy;
        // Only blend against a box that is actually being tracked.
        if (r_state == S_TRACK) begin
            w_new_tlx = f_avg(r_tlx, w_acc_minx);
            w_new_tly = f_avg(r_tly, w_acc_miny);
            w_new_brx = f_avg(r_brx, w_acc_maxx);
            w_new_bry = f_avg(r_bry, w_acc_maxy);
        end
    end
`else
    always_comb begin
        w_new_tlx = w_acc_minx;
        w_new_tly = w_acc_miny;
        w_new_brx = w_acc_maxx;
        w_new_bry = w_acc_maxy;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_SEARCH;
            r_miss      <= '0;
            r_minx      <= '1;
            r_miny      <= '1;
            r_maxx      <= '0;
            r_maxy      <= '0;
            r_cnt       <= '0;
            r_tlx       <= '0;
            r_tly       <= '0;
            r_brx       <= '0;
            r_bry       <= '0;
            r_box_valid <= 1'b0;
            r_lost      <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_miss      <= w_miss_nxt;
            r_minx      <= w_acc_minx;
            r_miny      <= w_acc_miny;
            r_maxx      <= w_acc_maxx;
            r_maxy      <= w_acc_maxy;
            r_cnt       <= w_acc_cnt;
            r_box_valid <= w_commit;
            r_lost      <= w_lost;
            if (w_commit) begin
                r_tlx <= w_new_tlx;
                r_tly <= w_new_tly;
                r_brx <= w_new_brx;
                r_bry <= w_new_bry;
            end
            if (w_frame_end) begin
                r_pix_count <= w_acc_cnt;
            end
        end
    end

    assign Tracktlx  = r_tlx;
    assign Tracktly  = r_tly;
    assign Trackbrx  = r_brx;
    assign Trackbry  = r_bry;
    assign box_valid = r_box_valid;
    assign locked    = (r_state == S_TRACK);
    assign lost      = r_lost;
    assign pix_count = r_pix_count;

endmodule

// File: tb/tb_bbox_tracker.sv
// ---------------------------------------------------------------------------
// tb_bbox_tracker
//
// Directed bench for bbox_tracker at default parameters (640x480, MARGIN 5,
// THRESH 254, MIN_PIXELS 4, LOST_FRAMES 8). Frames are driven sparsely: the
// frame-start pixel, the pixels of interest, then the frame-end pixel.
// ---------------------------------------------------------------------------
module tb_bbox_tracker;

`ifdef TRACKER_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  DrawX, DrawY;
    logic [9:0]  VGA_R, VGA_G, VGA_B;
    logic [9:0]  Tracktlx, Tracktly, Trackbrx, Trackbry;
    logic        box_valid, locked, lost, match;
    logic [18:0] pix_count;

    int checks = 0;
    int errors = 0;

    bbox_tracker dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .Tracktlx  (Tracktlx),
        .Tracktly  (Tracktly),
        .Trackbrx  (Trackbrx),
        .Trackbry  (Trackbry),
        .box_valid (box_valid),
        .locked    (locked),
        .lost      (lost),
        .match     (match),
        .pix_count (pix_count)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input int r, input int g, input int b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        VGA_R = 10'(r);
        VGA_G = 10'(g);
        VGA_B = 10'(b);
        #1;
    endtask

    task automatic px(input int x, input int y, input bit white);
        int c;
        c = white ? 1023 : 0;
        set_pix(x, y, c, c, c);
        step();
    endtask

    task automatic patch(input int x0, input int y0, input int x1, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                px(x, y, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        set_pix(650, 10, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL reset_offscreen_match got %0b exp 0", match);
        end
        step();
        step();
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== 40'd0) begin
            errors++;
            $display("FAIL reset_box got %0d,%0d,%0d,%0d exp 0,0,0,0",
                     Tracktlx, Tracktly, Trackbrx, Trackbry);
        end
        checks++;
        if ({box_valid, lost, locked} !== 3'b000 || pix_count !== 19'd0) begin
            errors++;
            $display("FAIL reset_flags got bv=%0b lost=%0b locked=%0b cnt=%0d exp 0,0,0,0",
                     box_valid, lost, locked, pix_count);
        end
        RESET = 1'b0;
        px(650, 10, 1'b0);
    endtask

    task automatic test_acquire();
        px(0, 0, 1'b0);
        patch(100, 50, 119, 59);
        px(639, 479, 1'b0);
        checks++;
        if (box_valid !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL acquire_flags got bv=%0b locked=%0b exp 1,1", box_valid, locked);
        end
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd100, 10'd50, 10'd119, 10'd59}) begin
            errors++;
            $display("FAIL acquire_box got %0d,%0d,%0d,%0d exp 100,50,119,59",
                     Tracktlx, Tracktly, Trackbrx, Trackbry);
        end
        checks++;
        if (pix_count !== 19'd200) begin
            errors++;
            $display("FAIL acquire_count got %0d exp 200", pix_count);
        end
        px(650, 10, 1'b0);
        checks++;
        if (box_valid !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL acquire_pulse got bv=%0b locked=%0b exp 0,1", box_valid, locked);
        end
    endtask

    task automatic test_window_ignore();
        px(0, 0, 1'b0);
        set_pix(300, 300, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL ignore_far_match got %0b exp 0", match);
        end
        step();
        set_pix(94, 50, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL ignore_left_edge got %0b exp 0", match);
        end
        step();
        set_pix(125, 50, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL ignore_right_edge got %0b exp 0", match);
        end
        step();
        patch(100, 50, 119, 59);
        px(639, 479, 1'b0);
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd100, 10'd50, 10'd119, 10'd59} ||
            pix_count !== 19'd200 || box_valid !== 1'b1) begin
            errors++;
            $display("FAIL ignore_box got %0d,%0d,%0d,%0d cnt=%0d bv=%0b exp 100,50,119,59 cnt=200 bv=1",
                     Tracktlx, Tracktly, Trackbrx, Trackbry, pix_count, box_valid);
        end
        px(650, 10, 1'b0);
    endtask

    task automatic test_lost();
        for (int f = 1; f <= 8; f++) begin
            px(0, 0, 1'b0);
            px(639, 479, 1'b0);
            if (f < 8) begin
                checks++;
                if ({locked, lost} !== 2'b10) begin
                    errors++;
                    $display("FAIL lost_frame%0d got locked=%0b lost=%0b exp 1,0", f, locked, lost);
                end
            end else begin
                checks++;
                if ({locked, lost, box_valid} !== 3'b010 || pix_count !== 19'd0) begin
                    errors++;
                    $display("FAIL lost_pulse got locked=%0b lost=%0b bv=%0b cnt=%0d exp 0,1,0,0",
                             locked, lost, box_valid, pix_count);
                end
            end
        end
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd100, 10'd50, 10'd119, 10'd59}) begin
            errors++;
            $display("FAIL lost_box_held got %0d,%0d,%0d,%0d exp 100,50,119,59",
                     Tracktlx, Tracktly, Trackbrx, Trackbry);
        end
        px(650, 10, 1'b0);
        checks++;
        if (lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_one_cycle got %0b exp 0", lost);
        end
    endtask

    task automatic test_search_few();
        px(0, 0, 1'b0);
        set_pix(300, 300, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL search_full_frame_match got %0b exp 1", match);
        end
        step();
        px(301, 300, 1'b1);
        set_pix(400, 100, 254, 254, 253);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL thresh_below got %0b exp 0", match);
        end
        step();
        set_pix(600, 400, 254, 254, 254);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL thresh_equal got %0b exp 1", match);
        end
        step();
        px(639, 479, 1'b0);
        checks++;
        if ({box_valid, locked} !== 2'b00 || pix_count !== 19'd3) begin
            errors++;
            $display("FAIL search_few got bv=%0b locked=%0b cnt=%0d exp 0,0,3",
                     box_valid, locked, pix_count);
        end
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd100, 10'd50, 10'd119, 10'd59}) begin
            errors++;
            $display("FAIL search_few_box got %0d,%0d,%0d,%0d exp 100,50,119,59",
                     Tracktlx, Tracktly, Trackbrx, Trackbry);
        end
        px(650, 10, 1'b0);
    endtask

    task automatic test_clamp();
        logic [39:0] exp_box;
        px(0, 0, 1'b0);
        px(2, 1, 1'b1);
        px(5, 5, 1'b1);
        px(6, 6, 1'b1);
        px(10, 8, 1'b1);
        px(639, 479, 1'b0);
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd2, 10'd1, 10'd10, 10'd8} ||
            locked !== 1'b1) begin
            errors++;
            $display("FAIL clamp_lock got %0d,%0d,%0d,%0d locked=%0b exp 2,1,10,8 locked=1",
                     Tracktlx, Tracktly, Trackbrx, Trackbry, locked);
        end
        px(650, 10, 1'b0);
        // Window now x 0..15, y 0..13.
        set_pix(0, 0, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL clamp_origin_match got %0b exp 1", match);
        end
        step();
        set_pix(15, 13, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL clamp_far_corner got %0b exp 1", match);
        end
        step();
        set_pix(16, 5, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL clamp_x_outside got %0b exp 0", match);
        end
        step();
        set_pix(5, 14, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL clamp_y_outside got %0b exp 0", match);
        end
        step();
        px(3, 3, 1'b1);
        px(4, 4, 1'b1);
        px(639, 479, 1'b0);
        exp_box = SMOOTH ? {10'd1, 10'd0, 10'd12, 10'd10} : {10'd0, 10'd0, 10'd15, 10'd13};
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== exp_box ||
            pix_count !== 19'd4 || box_valid !== 1'b1) begin
            errors++;
            $display("FAIL clamp_box got %0d,%0d,%0d,%0d cnt=%0d bv=%0b exp %0d,%0d,%0d,%0d cnt=4 bv=1",
                     Tracktlx, Tracktly, Trackbrx, Trackbry, pix_count, box_valid,
                     exp_box[39:30], exp_box[29:20], exp_box[19:10], exp_box[9:0]);
        end
        px(650, 10, 1'b0);
    endtask

    task automatic test_smooth();
        logic [39:0] exp_box;
        RESET = 1'b1;
        px(650, 10, 1'b0);
        RESET = 1'b0;
        test_acquire();
        px(0, 0, 1'b0);
        patch(104, 54, 123, 63);
        px(639, 479, 1'b0);
        exp_box = SMOOTH ? {10'd102, 10'd52, 10'd121, 10'd61} : {10'd104, 10'd54, 10'd123, 10'd63};
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== exp_box || pix_count !== 19'd200) begin
            errors++;
            $display("FAIL smooth_box got %0d,%0d,%0d,%0d cnt=%0d exp %0d,%0d,%0d,%0d cnt=200",
                     Tracktlx, Tracktly, Trackbrx, Trackbry, pix_count,
                     exp_box[39:30], exp_box[29:20], exp_box[19:10], exp_box[9:0]);
        end
        px(650, 10, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        RESET = 1'b1;
        px(650, 10, 1'b0);
        RESET = 1'b0;
        px(0, 0, 1'b0);
        for (int x = 10; x < 20; x++) px(x, 20, 1'b1);
        RESET = 1'b1;
        px(30, 20, 1'b0);
        RESET = 1'b0;
        px(200, 200, 1'b1);
        px(201, 200, 1'b1);
        px(202, 201, 1'b1);
        set_pix(639, 479, 1023, 1023, 1023);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL midreset_end_match got %0b exp 1", match);
        end
        step();
        checks++;
        if ({Tracktlx, Tracktly, Trackbrx, Trackbry} !== {10'd200, 10'd200, 10'd639, 10'd479} ||
            pix_count !== 19'd4 || box_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_box got %0d,%0d,%0d,%0d cnt=%0d bv=%0b exp 200,200,639,479 cnt=4 bv=1",
                     Tracktlx, Tracktly, Trackbrx, Trackbry, pix_count, box_valid);
        end
        px(650, 10, 1'b0);
    endtask

    task automatic test_reset_at_frame_end();
        px(0, 0, 1'b0);
        px(300, 300, 1'b1);
        px(301, 300, 1'b1);
        px(302, 300, 1'b1);
        px(303, 300, 1'b1);
        RESET = 1'b1;
        px(639, 479, 1'b1);
        checks++;
        if ({box_valid, locked} !== 2'b00 || pix_count !== 19'd0 ||
            {Tracktlx, Tracktly, Trackbrx, Trackbry} !== 40'd0) begin
            errors++;
            $display("FAIL reset_priority got bv=%0b locked=%0b cnt=%0d box=%0d,%0d,%0d,%0d exp all 0",
                     box_valid, locked, pix_count, Tracktlx, Tracktly, Trackbrx, Trackbry);
        end
        RESET = 1'b0;
        px(650, 10, 1'b0);
        checks++;
        if ({box_valid, locked, lost} !== 3'b000) begin
            errors++;
            $display("FAIL reset_priority_after got bv=%0b locked=%0b lost=%0b exp 0,0,0",
                     box_valid, locked, lost);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        RESET = 1'b1;
        DrawX = 10'd650;
        DrawY = 10'd10;
        VGA_R = '0;
        VGA_G = '0;
        VGA_B = '0;
        step();
        test_reset();
        test_acquire();
        test_window_ignore();
        test_lost();
        test_search_few();
        test_clamp();
        test_smooth();
        test_reset_mid_frame();
        test_reset_at_frame_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
